mem_responder: RTL and testbench

// - Memory-side responder for the accelerator's word-addressed data-memory interface (wvalid/wready/waddr/wdata, rvalid/rready/raddr/rdata).
// - Backs requests with an on-chip single-port word array and returns data after a fixed latency.
// - Serves as the accelerator's data memory in simulation and FPGA bring-up. rready acts as a one-cycle data-valid strobe and wready as a one-cycle write-done strobe.

---
 rtl/mem_responder_pkg.sv | 26 ++
 rtl/mem_responder_sram_1p.sv | 40 ++++
 rtl/mem_responder.sv | 178 +++++++++++++++++
 tb/tb_mem_responder.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_responder_pkg.sv
// rtl/mem_responder_pkg.sv - shared widths, FSM encoding and address helper for mem_responder
//
// Purpose: constants shared by the responder top and its storage array.
//   MEM_ADDR_W / MEM_DATA_W : interface address and data widths.
//   resp_state_e            : responder FSM encoding.
//   addr_out_of_range       : true when any address bit at or above depth_log2 is set.
// Ports: none (package).

package mem_responder_pkg;

  localparam int MEM_ADDR_W = 26;
  localparam int MEM_DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WR_ACK  = 2'd1,
    ST_RD_WAIT = 2'd2,
    ST_RD_RESP = 2'd3
  } resp_state_e;

  function automatic logic addr_out_of_range(input logic [MEM_ADDR_W-1:0] addr,
                                             input int unsigned           depth_log2);
    return (addr >> depth_log2) != '0;
  endfunction

endpackage

// File: rtl/mem_responder_sram_1p.sv
// rtl/mem_responder_sram_1p.sv - single-port synchronous word array with registered read port
//
// Purpose: the only storage of mem_responder; one shared address, one write
//   port and a registered read port so it maps onto block RAM. Contents are
//   never reset.
// Ports:
//   clk_i    in   clock, rising edge
//   we_i     in   write enable: mem[addr_i] <= wdata_i
//   re_i     in   read enable: rdata_o <= mem[addr_i] (held otherwise)
//   addr_i   in   word address shared by read and write
//   wdata_i  in   write data
//   rdata_o  out  registered read data

module mem_responder_sram_1p #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - word-addressed memory responder with fixed read latency
//
// Purpose: answers write/read requests from the accelerator data-memory
//   interface using a single-port on-chip array. Writes commit at acceptance
//   and pulse wready the next cycle; reads pulse rready RD_LAT+1 cycles after
//   acceptance. Out-of-range addresses set the sticky oob_err flag.
// Optional feature: define MEM_STALL_EN to build a 16-bit LFSR that lets IDLE
//   accept a request only in cycles where lfsr[0]==0.
// Ports:
//   clk      in   clock, rising edge
//   rst      in   synchronous active-high reset (array contents kept)
//   wvalid   in   write request, held until wready
//   wready   out  one-cycle pulse: write committed
//   waddr    in   write word address
//   wdata    in   write data
//   rvalid   in   read request, held until rready
//   rready   out  one-cycle pulse: rdata valid
//   raddr    in   read word address
//   rdata    out  read data, holds last returned value
//   oob_err  out  sticky out-of-range address flag
//   busy     out  FSM not in IDLE

module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int          DEPTH_LOG2 = 16,
  parameter int          RD_LAT     = 2,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wvalid,
  output logic                  wready,
  input  logic [MEM_ADDR_W-1:0] waddr,
  input  logic [MEM_DATA_W-1:0] wdata,
  input  logic                  rvalid,
  output logic                  rready,
  input  logic [MEM_ADDR_W-1:0] raddr,
  output logic [MEM_DATA_W-1:0] rdata,
  output logic                  oob_err,
  output logic                  busy
);

  if (DEPTH_LOG2 < 4 || DEPTH_LOG2 > MEM_ADDR_W || RD_LAT < 1 || RD_LAT > 15 ||
      LFSR_SEED == 16'h0) begin : g_bad_params
    $error("mem_responder: parameter out of range");
  end

  resp_state_e             state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [DEPTH_LOG2-1:0]   rd_idx_q, rd_idx_d;
  logic                    rd_oob_q, rd_oob_d;
  logic                    oob_err_q, oob_err_d;
  logic [MEM_DATA_W-1:0]   rdata_q, rdata_d;

  logic                    accept;
  logic                    waddr_oob, raddr_oob;
  logic                    mem_we, mem_re;
  logic [DEPTH_LOG2-1:0]   mem_addr;
  logic [MEM_DATA_W-1:0]   mem_rdata;
  logic [MEM_DATA_W-1:0]   rd_word;

`ifdef MEM_STALL_EN
  logic [15:0] lfsr_q, lfsr_d;

  // Fibonacci taps 16,14,13,11 -> bits 15,13,12,10
  assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign accept = ~lfsr_q[0];
`else
  assign accept = 1'b1;
`endif

  assign waddr_oob = addr_out_of_range(waddr, DEPTH_LOG2);
  assign raddr_oob = addr_out_of_range(raddr, DEPTH_LOG2);

  // Out-of-range reads never enable the array, so its stale output is masked here.
  assign rd_word = rd_oob_q ? '0 : mem_rdata;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rd_idx_d  = rd_idx_q;
    rd_oob_d  = rd_oob_q;
    oob_err_d = oob_err_q;
    rdata_d   = rdata_q;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_addr  = rd_idx_q;

    unique case (state_q)
      ST_IDLE: begin
        if (accept && wvalid) begin
          // Write commits on this edge; a pending read waits for the next IDLE.
          mem_addr = waddr[DEPTH_LOG2-1:0];
          if (waddr_oob) begin
            oob_err_d = 1'b1;
          end else begin
            mem_we = 1'b1;
          end
          state_d = ST_WR_ACK;
        end else if (accept && rvalid) begin
          rd_idx_d = raddr[DEPTH_LOG2-1:0];
          rd_oob_d = raddr_oob;
          if (raddr_oob) begin
            oob_err_d = 1'b1;
          end
          cnt_d   = 4'(RD_LAT - 1);
          state_d = ST_RD_WAIT;
        end
      end
      ST_WR_ACK: begin
        state_d = ST_IDLE;
      end
      ST_RD_WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          mem_re  = ~rd_oob_q;
          state_d = ST_RD_RESP;
        end
      end
      ST_RD_RESP: begin
        rdata_d = rd_word;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 4'd0;
      rd_idx_q  <= '0;
      rd_oob_q  <= 1'b0;
      oob_err_q <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rd_idx_q  <= rd_idx_d;
      rd_oob_q  <= rd_oob_d;
      oob_err_q <= oob_err_d;
      rdata_q   <= rdata_d;
    end
  end

  mem_responder_sram_1p #(
    .ADDR_W (DEPTH_LOG2),
    .DATA_W (MEM_DATA_W)
  ) u_sram (
    .clk_i   (clk),
    .we_i    (mem_we),
    .re_i    (mem_re),
    .addr_i  (mem_addr),
    .wdata_i (wdata),
    .rdata_o (mem_rdata)
  );

  // During RD_RESP the fresh array word drives rdata; afterwards the held copy does.
  assign rdata   = (state_q == ST_RD_RESP) ? rd_word : rdata_q;
  assign wready  = (state_q == ST_WR_ACK);
  assign rready  = (state_q == ST_RD_RESP);
  assign oob_err = oob_err_q;
  assign busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - self-checking bench for mem_responder

module tb_mem_responder;

  localparam int DEPTH_LOG2 = 16;
  localparam int RD_LAT     = 2;
  localparam int TIMEOUT    = 64;
`ifdef MEM_STALL_EN
  localparam bit STALL = 1'b1;
`else
  localparam bit STALL = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        wvalid;
  logic        wready;
  logic [25:0] waddr;
  logic [31:0] wdata;
  logic        rvalid;
  logic        rready;
  logic [25:0] raddr;
  logic [31:0] rdata;
  logic        oob_err;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  bit [31:0] ref_mem [int unsigned];
  bit        ref_oob = 1'b0;

  int wr_pulses = 0;
  int rd_pulses = 0;

  mem_responder #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .RD_LAT     (RD_LAT),
    .LFSR_SEED  (16'hACE1)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .wvalid  (wvalid),
    .wready  (wready),
    .waddr   (waddr),
    .wdata   (wdata),
    .rvalid  (rvalid),
    .rready  (rready),
    .raddr   (raddr),
    .rdata   (rdata),
    .oob_err (oob_err),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wready) wr_pulses++;
    if (rready) rd_pulses++;
  end

  function automatic bit is_oob(input logic [25:0] a);
    return int'(a) >= (1 << DEPTH_LOG2);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_write(input logic [25:0] a, input logic [31:0] d, output int lat);
    waddr  = a;
    wdata  = d;
    wvalid = 1'b1;
    lat    = -1;
    for (int c = 1; c <= TIMEOUT; c++) begin
      tick();
      if (wready) begin
        lat = c;
        break;
      end
    end
    wvalid = 1'b0;
    waddr  = 26'($urandom);
    wdata  = $urandom;
    if (is_oob(a)) ref_oob = 1'b1;
    else ref_mem[int'(a)] = d;
  endtask

  task automatic do_read(input logic [25:0] a, output logic [31:0] d, output int lat);
    raddr  = a;
    rvalid = 1'b1;
    lat    = -1;
    d      = 32'hx;
    for (int c = 1; c <= TIMEOUT; c++) begin
      tick();
      if (rready) begin
        lat = c;
        d   = rdata;
        break;
      end else if (busy) begin
        raddr = 26'($urandom);
      end
    end
    rvalid = 1'b0;
    if (is_oob(a)) ref_oob = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle(3);
    checks++; if (wready !== 1'b0) begin failures++; $display("FAIL reset_wready: got %b expected 0", wready); end
    checks++; if (rready !== 1'b0) begin failures++; $display("FAIL reset_rready: got %b expected 0", rready); end
    checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata: got %h expected 0", rdata); end
    checks++; if (oob_err !== 1'b0) begin failures++; $display("FAIL reset_oob_err: got %b expected 0", oob_err); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
    rst = 1'b0;
    tick();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL post_reset_busy: got %b expected 0", busy); end
    ref_oob = 1'b0;
  endtask

  task automatic test_write_read();
    int lat;
    logic [31:0] d;
    do_write(26'h10, 32'h1234_5678, lat);
    checks++;
    if (lat == -1 || (STALL ? lat < 1 : lat != 1)) begin
      failures++; $display("FAIL wr_latency: got %0d expected 1", lat);
    end
    idle(1);
    checks++; if (wready !== 1'b0) begin failures++; $display("FAIL wready_width: got %b expected 0", wready); end
    do_read(26'h10, d, lat);
    checks++;
    if (lat == -1 || (STALL ? lat < RD_LAT + 1 : lat != RD_LAT + 1)) begin
      failures++; $display("FAIL rd_latency: got %0d expected %0d", lat, RD_LAT + 1);
    end
    checks++; if (d !== 32'h1234_5678) begin failures++; $display("FAIL rd_data: got %h expected 12345678", d); end
    idle(1);
    checks++; if (rready !== 1'b0 || rdata !== 32'h1234_5678) begin
      failures++; $display("FAIL rd_hold: got rready=%b rdata=%h expected 0/12345678", rready, rdata);
    end
  endtask

  task automatic test_simultaneous();
    int wl = -1;
    int rl = -1;
    logic [31:0] d = 32'h0;
    waddr  = 26'h20;
    wdata  = 32'hCAFE_F00D;
    raddr  = 26'h20;
    wvalid = 1'b1;
    rvalid = 1'b1;
    for (int c = 1; c <= 2 * TIMEOUT; c++) begin
      tick();
      if (wready) begin
        wl = c;
        wvalid = 1'b0;
        ref_mem[32'h20] = 32'hCAFE_F00D;
      end
      if (rready) begin
        rl = c;
        d  = rdata;
        rvalid = 1'b0;
        break;
      end
    end
    wvalid = 1'b0;
    rvalid = 1'b0;
    checks++;
    if (wl == -1 || (STALL ? wl < 1 : wl != 1)) begin
      failures++; $display("FAIL sim_wr_latency: got %0d expected 1", wl);
    end
    checks++;
    if (rl == -1 || wl == -1 || (STALL ? rl < wl + 2 + RD_LAT : rl != wl + 2 + RD_LAT)) begin
      failures++; $display("FAIL sim_rd_latency: got %0d expected %0d", rl, wl + 2 + RD_LAT);
    end
    checks++; if (d !== 32'hCAFE_F00D) begin failures++; $display("FAIL sim_rd_data: got %h expected cafef00d", d); end
    idle(1);
  endtask

  task automatic test_stream();
    int lat;
    int idx  = 0;
    int last = 0;
    for (int i = 0; i < 8; i++) begin
      do_write(26'(i), 32'(i), lat);
      idle(1);
    end
    raddr  = 26'h0;
    rvalid = 1'b1;
    for (int c = 1; c <= 8 * TIMEOUT && idx < 8; c++) begin
      tick();
      if (rready) begin
        checks++;
        if (rdata !== 32'(idx)) begin
          failures++; $display("FAIL stream_data[%0d]: got %h expected %h", idx, rdata, 32'(idx));
        end
        checks++;
        if (idx == 0) begin
          if (STALL ? c < RD_LAT + 1 : c != RD_LAT + 1) begin
            failures++; $display("FAIL stream_first: got %0d expected %0d", c, RD_LAT + 1);
          end
        end else if (STALL ? c - last < RD_LAT + 2 : c - last != RD_LAT + 2) begin
          failures++; $display("FAIL stream_spacing[%0d]: got %0d expected %0d", idx, c - last, RD_LAT + 2);
        end
        last = c;
        idx++;
        if (idx < 8) raddr = 26'(idx);
        else rvalid = 1'b0;
      end
    end
    rvalid = 1'b0;
    checks++; if (idx != 8) begin failures++; $display("FAIL stream_count: got %0d expected 8", idx); end
    idle(1);
  endtask

  task automatic test_oob();
    int lat;
    logic [31:0] d;
    do_write(26'h0, 32'hDEAD_BEEF, lat);
    idle(1);
    checks++; if (oob_err !== 1'b0) begin failures++; $display("FAIL oob_pre: got %b expected 0", oob_err); end
    do_read(26'h1_0000, d, lat);
    checks++; if (lat == -1 || d !== 32'h0) begin failures++; $display("FAIL oob_rd_data: got %h lat=%0d expected 0", d, lat); end
    checks++; if (oob_err !== 1'b1) begin failures++; $display("FAIL oob_rd_flag: got %b expected 1", oob_err); end
    idle(1);
    do_write(26'h1_0005, 32'hBAD0_BAD0, lat);
    checks++;
    if (lat == -1 || (STALL ? lat < 1 : lat != 1)) begin
      failures++; $display("FAIL oob_wr_latency: got %0d expected 1", lat);
    end
    idle(1);
    do_read(26'h5, d, lat);
    checks++; if (d !== ref_mem[32'h5]) begin failures++; $display("FAIL oob_wr_dropped: got %h expected %h", d, ref_mem[32'h5]); end
    checks++; if (oob_err !== 1'b1) begin failures++; $display("FAIL oob_sticky: got %b expected 1", oob_err); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ref_oob = 1'b0;
    checks++; if (oob_err !== 1'b0) begin failures++; $display("FAIL oob_clear: got %b expected 0", oob_err); end
  endtask

  task automatic test_reset_mid_txn();
    int lat;
    logic [31:0] d;
    bit seen = 1'b0;
    bit acc  = 1'b0;
    do_write(26'h30, 32'h5555_AAAA, lat);
    idle(1);
    raddr  = 26'h30;
    rvalid = 1'b1;
    for (int c = 0; c < TIMEOUT && !acc; c++) begin
      tick();
      if (busy) acc = 1'b1;
    end
    checks++; if (!acc) begin failures++; $display("FAIL midrd_accept: got busy=0 expected 1"); end
    rst    = 1'b1;
    rvalid = 1'b0;
    tick();
    rst = 1'b0;
    checks++; if (busy !== 1'b0 || rready !== 1'b0) begin
      failures++; $display("FAIL midrd_abort: got busy=%b rready=%b expected 0/0", busy, rready);
    end
    for (int c = 0; c < RD_LAT + 4; c++) begin
      tick();
      if (rready) seen = 1'b1;
    end
    checks++; if (seen) begin failures++; $display("FAIL midrd_no_pulse: got rready pulse expected none"); end
    do_read(26'h30, d, lat);
    checks++; if (d !== 32'h5555_AAAA) begin failures++; $display("FAIL midrd_old: got %h expected 5555aaaa", d); end
    idle(1);
    do_write(26'h31, 32'h0F0F_1234, lat);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (wready !== 1'b0) begin failures++; $display("FAIL midwr_abort: got %b expected 0", wready); end
    do_read(26'h31, d, lat);
    checks++; if (d !== 32'h0F0F_1234) begin failures++; $display("FAIL midwr_kept: got %h expected 0f0f1234", d); end
    idle(1);
    ref_oob = 1'b0;
  endtask

  task automatic test_random();
    int lat;
    int kind;
    int w0, r0;
    int nw = 0;
    int nr = 0;
    logic [25:0] a;
    logic [31:0] d;
    logic [31:0] exp;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ref_oob = 1'b0;
    for (int i = 0; i < 64; i++) begin
      do_write(26'(32'h100 + i), $urandom, lat);
      idle(1);
    end
    w0 = wr_pulses;
    r0 = rd_pulses;
    for (int op = 0; op < 1000; op++) begin
      idle($urandom_range(1, 3));
      kind = $urandom_range(0, 9);
      if (kind <= 1) a = {10'($urandom_range(1, 1023)), 16'($urandom)};
      else a = 26'(32'h100 + $urandom_range(0, 63));
      if (kind == 0 || (kind >= 2 && kind <= 5)) begin
        do_write(a, $urandom, lat);
        nw++;
        checks++;
        if (lat == -1 || (STALL ? lat < 1 : lat != 1)) begin
          failures++; $display("FAIL rnd_wr_latency[%0d]: got %0d expected 1", op, lat);
        end
      end else begin
        exp = is_oob(a) ? 32'h0 : ref_mem[int'(a)];
        do_read(a, d, lat);
        nr++;
        checks++;
        if (lat == -1 || (STALL ? lat < RD_LAT + 1 : lat != RD_LAT + 1)) begin
          failures++; $display("FAIL rnd_rd_latency[%0d]: got %0d expected %0d", op, lat, RD_LAT + 1);
        end
        checks++;
        if (d !== exp) begin
          failures++; $display("FAIL rnd_rd_data[%0d]: addr %h got %h expected %h", op, a, d, exp);
        end
      end
      checks++;
      if (oob_err !== ref_oob) begin
        failures++; $display("FAIL rnd_oob_err[%0d]: got %b expected %b", op, oob_err, ref_oob);
      end
    end
    idle(2);
    checks++; if (wr_pulses - w0 != nw) begin failures++; $display("FAIL rnd_wr_pulses: got %0d expected %0d", wr_pulses - w0, nw); end
    checks++; if (rd_pulses - r0 != nr) begin failures++; $display("FAIL rnd_rd_pulses: got %0d expected %0d", rd_pulses - r0, nr); end
  endtask

  initial begin
    rst    = 1'b1;
    wvalid = 1'b0;
    rvalid = 1'b0;
    waddr  = '0;
    wdata  = '0;
    raddr  = '0;
    test_reset();
    test_write_read();
    test_simultaneous();
    test_stream();
    test_oob();
    test_reset_mid_txn();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
